// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the 4-bit processor microcode ROM: PC, instruction register, C/Z flags, phase.
// Optional FETCH_SINGLE_STEP_EN adds a synchronized step input that releases one instruction per rising edge.
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [7:0]  prog_data,
    input  logic [12:0] ctrl,
    input  logic        alu_c,
    input  logic        alu_z,
    output logic [11:0] pc,
    output logic [6:0]  rom_addr,
    output logic        rom_en,
    output logic [3:0]  oprnd,
    output logic        phase,
    output logic        c_flag,
    output logic        z_flag
);

    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    logic [11:0] pc_q, pc_d;
    logic [7:0]  instr_q, instr_d;
    logic        phase_q, phase_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic        advance;
    logic        run_ok;

    // Only incPC, loadPC and loadFlags matter here; the rest steer the datapath.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[10], ctrl[8:0]};

`ifdef FETCH_SINGLE_STEP_EN
    logic step_meta_q, step_sync_q, step_prev_q;
    logic armed_q, armed_d;
    logic step_rise;

    assign step_rise = step_sync_q & ~step_prev_q;
    // Execute always completes; a new fetch needs an armed step.
    assign run_ok    = (phase_q == PH_EXEC) | armed_q;

    always_comb begin
        armed_d = armed_q;
        if (en && phase_q == PH_FETCH && armed_q)
            armed_d = 1'b0;
        else if (step_rise && !armed_q && phase_q == PH_FETCH)
            armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            step_meta_q <= step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
            armed_q     <= armed_d;
        end
    end
`else
    assign run_ok = 1'b1;
`endif

    assign advance = en & run_ok;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= 12'h000;
            instr_q <= 8'h00;
            phase_q <= PH_FETCH;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            phase_q <= phase_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Next-state logic; loadPC takes priority over incPC
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        phase_d = phase_q;
        c_d     = c_q;
        z_d     = z_q;
        if (advance) begin
            phase_d = (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
            if (phase_q == PH_FETCH)
                instr_d = prog_data;
            if (ctrl[11])
                pc_d = {instr_q[3:0], prog_data};
            else if (ctrl[12])
                pc_d = pc_q + 12'd1;
            if (ctrl[9]) begin
                c_d = alu_c;
                z_d = alu_z;
            end
        end
    end

    // Outputs
    always_comb begin
        pc       = pc_q;
        rom_addr = {instr_q[7:4], c_q, z_q, phase_q};
        rom_en   = reset & advance;
        oprnd    = instr_q[3:0];
        phase    = phase_q;
        c_flag   = c_q;
        z_flag   = z_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (default build) against a behavioural model of pc/instr/flags/phase.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  prog_data = 8'h00;
    logic [12:0] ctrl = 13'h0000;
    logic        alu_c = 1'b0;
    logic        alu_z = 1'b0;
    logic [11:0] pc;
    logic [6:0]  rom_addr;
    logic        rom_en;
    logic [3:0]  oprnd;
    logic        phase;
    logic        c_flag;
    logic        z_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] m_pc;
    logic [7:0]  m_instr;
    logic        m_phase, m_c, m_z;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .en(en),
        .prog_data(prog_data), .ctrl(ctrl), .alu_c(alu_c), .alu_z(alu_z),
        .pc(pc), .rom_addr(rom_addr), .rom_en(rom_en), .oprnd(oprnd),
        .phase(phase), .c_flag(c_flag), .z_flag(z_flag)
    );

    function void model_reset();
        m_pc = 0; m_instr = 0; m_phase = 0; m_c = 0; m_z = 0;
    endfunction

    // One enabled edge: opcode byte captured in fetch, jump beats increment, flags on loadFlags.
    function void model_step();
        logic [11:0] npc;
        if (!en) return;
        npc = m_pc;
        if (ctrl[11])      npc = {m_instr[3:0], prog_data};
        else if (ctrl[12]) npc = (m_pc + 1) % 4096;
        if (ctrl[9]) begin m_c = alu_c; m_z = alu_z; end
        if (m_phase == 0) m_instr = prog_data;
        m_phase = ~m_phase;
        m_pc = npc;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0; en = 1; prog_data = 8'hA5; ctrl = 0;
        model_reset();
        #12;
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc got=%h exp=000", pc); end
        n_checks++; if (rom_addr !== 7'h00) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
        reset = 1;
        #1;
        n_checks++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL release_rom_en got=%b exp=1", rom_en); end
        n_checks++; if (phase !== 1'b0) begin n_fail++; $display("FAIL release_phase got=%b exp=0", phase); end
        ctrl = 13'h1008;
        tick();
        n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL first_pc got=%h exp=001", pc); end
        n_checks++; if (rom_addr !== 7'b1010_00_1) begin n_fail++; $display("FAIL first_rom_addr got=%b exp=1010001", rom_addr); end
        n_checks++; if (oprnd !== 4'h5) begin n_fail++; $display("FAIL first_oprnd got=%h exp=5", oprnd); end
        $display("test_reset: pc=%h rom_addr=%b", pc, rom_addr);
    endtask

    task automatic test_jump();
        ctrl = 0; tick();                            // finish execute
        prog_data = 8'h73; ctrl = 13'h1000; tick();  // fetch 0x73
        ctrl = 13'h1800; prog_data = 8'h4C; tick();  // both bits: jump wins
        n_checks++; if (pc !== 12'h34C) begin n_fail++; $display("FAIL jump_pc got=%h exp=34c", pc); end
        n_checks++; if (phase !== 1'b0) begin n_fail++; $display("FAIL jump_phase got=%b exp=0", phase); end
        n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL jump_model got=%h exp=%h", pc, m_pc); end
        $display("test_jump: pc=%h", pc);
    endtask

    task automatic test_flags();
        prog_data = 8'h10; ctrl = 0; tick();
        ctrl = 13'h0200; alu_c = 1; alu_z = 0; tick();
        n_checks++; if ({c_flag, z_flag} !== 2'b10) begin n_fail++; $display("FAIL flags_set got=%b exp=10", {c_flag, z_flag}); end
        n_checks++; if (rom_addr[2:1] !== 2'b10 || phase !== 1'b0) begin n_fail++; $display("FAIL flags_rom_addr got=%b exp=xxxx100", rom_addr); end
        ctrl = 0;
        for (int i = 0; i < 4; i++) begin
            alu_c = i[0]; alu_z = ~i[0];
            tick();
            n_checks++; if ({c_flag, z_flag} !== 2'b10) begin n_fail++; $display("FAIL flags_hold[%0d] got=%b exp=10", i, {c_flag, z_flag}); end
        end
        $display("test_flags: c=%b z=%b", c_flag, z_flag);
    endtask

    task automatic test_wrap();
        prog_data = 8'h0F; ctrl = 0; tick();
        prog_data = 8'hFF; ctrl = 13'h0800; tick();
        n_checks++; if (pc !== 12'hFFF) begin n_fail++; $display("FAIL wrap_setup got=%h exp=fff", pc); end
        ctrl = 13'h1000; tick();
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc got=%h exp=000", pc); end
        $display("test_wrap: pc=%h phase=%b", pc, phase);
    endtask

    task automatic test_enable();
        logic [11:0] s_pc;
        logic [6:0]  s_ra;
        s_pc = m_pc; s_ra = {m_instr[7:4], m_c, m_z, m_phase};
        en = 0;
        for (int i = 0; i < 5; i++) begin
            ctrl = 13'($urandom); prog_data = 8'($urandom); alu_c = 1'($urandom); alu_z = 1'($urandom);
            tick();
            n_checks++; if (pc !== s_pc || rom_addr !== s_ra) begin n_fail++; $display("FAIL en_hold[%0d] got=%h/%b exp=%h/%b", i, pc, rom_addr, s_pc, s_ra); end
            n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL en_rom_en[%0d] got=%b exp=0", i, rom_en); end
        end
        en = 1; ctrl = 13'h1000; tick();
        n_checks++; if (phase !== ~s_ra[0] || pc !== s_pc + 12'd1) begin n_fail++; $display("FAIL en_resume got=%b/%h exp=%b/%h", phase, pc, ~s_ra[0], s_pc + 12'd1); end
        $display("test_enable: resumed phase=%b pc=%h", phase, pc);
    endtask

    task automatic test_async_reset();
        if (m_phase) begin ctrl = 0; tick(); end
        prog_data = 8'h01; ctrl = 0; tick();
        prog_data = 8'h23; ctrl = 13'h0A00; alu_c = 1; alu_z = 1; tick();
        prog_data = 8'h99; ctrl = 0; tick();
        n_checks++; if (pc !== 12'h123 || phase !== 1'b1) begin n_fail++; $display("FAIL areset_setup got=%h/%b exp=123/1", pc, phase); end
        #2; reset = 0; model_reset(); #1;
        n_checks++; if (pc !== 12'h000 || rom_addr !== 7'h00 || oprnd !== 4'h0) begin n_fail++; $display("FAIL areset_clear got=%h/%b/%h exp=000/0000000/0", pc, rom_addr, oprnd); end
        n_checks++; if ({c_flag, z_flag, phase} !== 3'b000) begin n_fail++; $display("FAIL areset_flags got=%b exp=000", {c_flag, z_flag, phase}); end
        #1; reset = 1;
        prog_data = 8'h5A; ctrl = 13'h1000; tick();
        n_checks++; if (pc !== 12'h001 || rom_addr !== 7'b0101_00_1) begin n_fail++; $display("FAIL areset_restart got=%h/%b exp=001/0101001", pc, rom_addr); end
        $display("test_async_reset: pc=%h rom_addr=%b", pc, rom_addr);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            en = ($urandom_range(0, 3) != 0);
            ctrl = 13'($urandom); prog_data = 8'($urandom);
            alu_c = 1'($urandom); alu_z = 1'($urandom);
            tick();
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
            n_checks++; if (rom_addr !== {m_instr[7:4], m_c, m_z, m_phase}) begin n_fail++; $display("FAIL rand_rom_addr[%0d] got=%b exp=%b", i, rom_addr, {m_instr[7:4], m_c, m_z, m_phase}); end
            n_checks++; if (oprnd !== m_instr[3:0] || rom_en !== en) begin n_fail++; $display("FAIL rand_oprnd_en[%0d] got=%h/%b exp=%h/%b", i, oprnd, rom_en, m_instr[3:0], en); end
            $display("rand %0d: en=%b ctrl=%h prog=%h -> pc=%h rom_addr=%b", i, en, ctrl, prog_data, pc, rom_addr);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_flags();
        test_wrap();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
